instr_decode_pipe: RTL and testbench
====================================

Name: instr_decode_pipe

Overview:
Parametrised RV32I/M decode stage that sits between fetch and execute. It replaces the fixed, always-enabled decoder with a valid/ready pipeline stage that has a 2-entry skid buffer and a flush input. Illegal and system instructions are flagged as trap outputs instead of stopping simulation. B-type and J-type immediates are decoded separately and correctly.

Parameters:
XLEN, 32, datapath width; immediates sign-extended to XLEN.
EN_M, 1, 1 = decode the M extension (funct7 = 0000001 on ARITH); 0 = such instructions are illegal.
EN_SYS, 1, 1 = decode ECALL (0x00000073) and EBREAK (0x00100073); 0 = every SYS opcode is illegal.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  discard all held and incoming instructions.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage can accept; equals !skid_valid.
in_instr  in  32  raw instruction.
in_pc  in  XLEN  PC of in_instr.
out_valid  out  1  decoded entry presented to execute.
out_ready  in  1  execute accepts the entry.
out_pc  out  XLEN  PC carried through unchanged.
rs1_addr, rs2_addr, rd  out  5 each  register fields.
op  out  4  ALU/branch op: {0,funct3} ARITH/ARITH_I; {1,funct3} BCC; 1011 LUI; 1010 AUIPC/JAL; 0000 JALR/LOAD/STORE.
op_choice  out  1  instr[30] for ARITH, SRAI/SRLI; forced 0 for ADDI, JALR, LOAD, STORE.
use_imm  out  1  second operand is imm.
imm  out  XLEN  sign-extended immediate (I/S/B/U/J by opcode); 0 for R-type.
uncond_jmp, is_branch, is_mul  out  1 each  JAL/JALR; BCC; M-extension op (op carries funct3).
en_mem, mem_write, mem_read_unsigned  out  1 each  memory controls.
mem_size  out  2  instr[13:12].
en_wb, use_pcp4  out  1 each  writeback enable; write PC+4 (JAL/JALR).
illegal, ecall, ebreak  out  1 each  trap flags; when any is set, en_ex/en_mem/en_wb are 0.

Behaviour:
- Reset (async): out_valid=0, skid empty (in_ready=1), every decoded output 0, out_pc=0.
- Decode is combinational on in_instr; results are registered. Latency is 1 cycle from the accepting edge to out_valid.
- Storage is main register (drives outputs) plus skid register. in_ready is registered-derived and does not depend combinationally on out_ready.
- States and transitions:
  - EMPTY: accept → FULL.
  - FULL: accept and no pop → SKID; pop and no accept → EMPTY; accept and pop → FULL with the new entry.
  - SKID: pop → FULL (skid entry moves to main); in_ready=0.
- Pop is out_valid & out_ready. Accept is in_valid & in_ready.
- Order is preserved: the skid entry is always younger than the main entry.
- flush, with priority over everything: next edge → EMPTY. An instruction accepted in the flush cycle is discarded, and out_valid falls the cycle after flush.
- en_wb is forced to 0 when rd == 0. This is a register-write suppression only; loads still set en_mem.
- FENCE decodes as a valid NOP: all enables 0, illegal=0.
- illegal=1 in each of these cases: unknown opcode; ARITH funct7 not in {0000000, 0100000, (0000001 if EN_M)}; 0100000 paired with funct3 other than 000 or 101; SLLI/SRLI/SRAI with a bad funct7; BCC funct3 010 or 011; LOAD funct3 011, 110 or 111; STORE funct3 above 010; JALR funct3 non-zero; SYS other than ECALL/EBREAK, or any SYS when EN_SYS=0.
- Outputs are held stable while out_valid & !out_ready. No X values are ever driven.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 → 1 cycle later out_valid=1, op=0000, use_imm=1, imm=5, rd=1, en_wb=1, op_choice=0.
- sub x3,x1,x2 (0x402081B3) → op=0000, op_choice=1, use_imm=0, imm=0. beq x0,x0,-8 (0xFE000CE3) → is_branch=1, op=1000, imm=0xFFFFFFF8, en_wb=0.
- mul x5,x6,x7 (0x027302B3): with EN_M=1 → is_mul=1, op=0000, rd=5; with EN_M=0 → illegal=1, en_wb=0.
- ecall (0x00000073) → ecall=1 and all enables 0; 0x0000007F → illegal=1.
- Backpressure: out_ready=0 and 3 back-to-back valid instructions → two are accepted, in_ready=0 on the third cycle, outputs stable. Raising out_ready drains them in order with 1 pop per cycle.
- Flush while in SKID with in_valid=1 → next cycle out_valid=0, in_ready=1, and nothing from the flush cycle emerges. Asserting rst mid-stream clears outputs immediately, without a clock edge.

Source files
------------

// File: rtl/instr_decode_pipe_if.sv
// instr_decode_pipe_if: fetch->decode->execute handshake plus decoded-field bundle
// master: fetch/execute side (drives instruction, pc, out_ready)
// slave:  decode stage (drives in_ready, out_valid, out_pc and every decoded field)
interface instr_decode_pipe_if #(parameter int XLEN = 32);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc, out_pc, imm;
  logic [4:0] rs1_addr, rs2_addr, rd;
  logic [3:0] op;
  logic [1:0] mem_size;
  logic op_choice, use_imm, uncond_jmp, is_branch, is_mul;
  logic en_mem, mem_write, mem_read_unsigned, en_wb, use_pcp4;
  logic illegal, ecall, ebreak;
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd, op, op_choice, use_imm, imm,
           uncond_jmp, is_branch, is_mul, en_mem, mem_write, mem_read_unsigned, mem_size,
           en_wb, use_pcp4, illegal, ecall, ebreak
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd, op, op_choice, use_imm, imm,
           uncond_jmp, is_branch, is_mul, en_mem, mem_write, mem_read_unsigned, mem_size,
           en_wb, use_pcp4, illegal, ecall, ebreak
  );
endinterface

// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe: RV32I/M decode stage with valid/ready handshake, 2-entry skid buffer, flush and trap flags
// Ports: clk; rst (async, active-high); flush (drop held and incoming entries);
//   bus (slave): in_valid/in_ready/in_instr/in_pc from fetch, out_valid/out_ready, out_pc and decoded fields to execute.
module instr_decode_pipe #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1,
  parameter bit EN_SYS = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic flush,
  instr_decode_pipe_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] op;
    logic op_choice, use_imm;
    logic [XLEN-1:0] imm;
    logic uncond_jmp, is_branch, is_mul, en_mem, mem_write, mem_read_unsigned;
    logic [1:0] mem_size;
    logic en_wb, use_pcp4, illegal, ecall, ebreak;
  } dec_t;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t state, state_nx;
  dec_t d, main_q, skid_q;
  logic [31:0] ins;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic acc, pop, ld_main, ld_skid, from_skid;
  assign ins = bus.in_instr;
  assign f3 = ins[14:12];
  assign f7 = ins[31:25];
  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  always_comb begin
    d = '0;
    d.pc = bus.in_pc;
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd = ins[11:7];
    d.mem_size = ins[13:12];
    case (ins[6:0])
      7'b0110111: begin d.op = 4'b1011; d.use_imm = 1'b1; d.imm = imm_u; d.en_wb = 1'b1; end
      7'b0010111: begin d.op = 4'b1010; d.use_imm = 1'b1; d.imm = imm_u; d.en_wb = 1'b1; end
      7'b1101111: begin
        d.op = 4'b1010; d.use_imm = 1'b1; d.imm = imm_j;
        d.uncond_jmp = 1'b1; d.use_pcp4 = 1'b1; d.en_wb = 1'b1;
      end
      7'b1100111: begin
        d.illegal = f3 != 3'b000; d.use_imm = 1'b1; d.imm = imm_i;
        d.uncond_jmp = 1'b1; d.use_pcp4 = 1'b1; d.en_wb = 1'b1;
      end
      7'b1100011: begin
        d.illegal = f3[2:1] == 2'b01; d.op = {1'b1, f3}; d.is_branch = 1'b1; d.imm = imm_b;
      end
      7'b0000011: begin
        d.illegal = f3 == 3'b011 || f3[2:1] == 2'b11; d.use_imm = 1'b1; d.imm = imm_i;
        d.en_mem = 1'b1; d.mem_read_unsigned = f3[2]; d.en_wb = 1'b1;
      end
      7'b0100011: begin
        d.illegal = f3 > 3'b010; d.use_imm = 1'b1; d.imm = imm_s; d.en_mem = 1'b1; d.mem_write = 1'b1;
      end
      7'b0010011: begin
        d.op = {1'b0, f3}; d.use_imm = 1'b1; d.imm = imm_i; d.en_wb = 1'b1;
        d.op_choice = f3 == 3'b101 && ins[30];
        d.illegal = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      7'b0110011: begin
        d.op = {1'b0, f3}; d.en_wb = 1'b1; d.op_choice = ins[30];
        d.is_mul = EN_M && f7 == 7'b0000001;
        d.illegal = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) || d.is_mul);
      end
      7'b0001111: ;
      7'b1110011: begin
        d.ecall = EN_SYS && ins == 32'h0000_0073;
        d.ebreak = EN_SYS && ins == 32'h0010_0073;
        d.illegal = !(d.ecall || d.ebreak);
      end
      default: d.illegal = 1'b1;
    endcase
    // traps carry only their flags, pc and raw fields; nothing downstream may execute
    if (d.illegal || d.ecall || d.ebreak) begin
      d.op = '0; d.op_choice = 1'b0; d.use_imm = 1'b0; d.imm = '0;
      d.uncond_jmp = 1'b0; d.is_branch = 1'b0; d.is_mul = 1'b0;
      d.en_mem = 1'b0; d.mem_write = 1'b0; d.mem_read_unsigned = 1'b0;
      d.en_wb = 1'b0; d.use_pcp4 = 1'b0;
    end
    d.en_wb = d.en_wb && d.rd != 5'd0;
  end
  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  always_comb begin
    state_nx = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    from_skid = 1'b0;
    if (flush) state_nx = EMPTY;
    else case (state)
      EMPTY: begin ld_main = acc; state_nx = acc ? FULL : EMPTY; end
      FULL: begin
        ld_main = acc && pop;
        ld_skid = acc && !pop;
        state_nx = (acc && !pop) ? SKID : (pop && !acc) ? EMPTY : FULL;
      end
      SKID: begin ld_main = pop; from_skid = pop; state_nx = pop ? FULL : SKID; end
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nx;
      if (ld_main) main_q <= from_skid ? skid_q : d;
      if (ld_skid) skid_q <= d;
    end
  end
  assign bus.in_ready = state != SKID;
  assign bus.out_valid = state != EMPTY;
  assign bus.out_pc = main_q.pc;
  assign bus.rs1_addr = main_q.rs1;
  assign bus.rs2_addr = main_q.rs2;
  assign bus.rd = main_q.rd;
  assign bus.op = main_q.op;
  assign bus.op_choice = main_q.op_choice;
  assign bus.use_imm = main_q.use_imm;
  assign bus.imm = main_q.imm;
  assign bus.uncond_jmp = main_q.uncond_jmp;
  assign bus.is_branch = main_q.is_branch;
  assign bus.is_mul = main_q.is_mul;
  assign bus.en_mem = main_q.en_mem;
  assign bus.mem_write = main_q.mem_write;
  assign bus.mem_read_unsigned = main_q.mem_read_unsigned;
  assign bus.mem_size = main_q.mem_size;
  assign bus.en_wb = main_q.en_wb;
  assign bus.use_pcp4 = main_q.use_pcp4;
  assign bus.illegal = main_q.illegal;
  assign bus.ecall = main_q.ecall;
  assign bus.ebreak = main_q.ebreak;
endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb_instr_decode_pipe: randomized + directed check of the decode stage against a queue/rule model
module tb_instr_decode_pipe;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] op;
    logic op_choice, use_imm;
    logic [31:0] imm;
    logic uncond_jmp, is_branch, is_mul, en_mem, mem_write, mem_read_unsigned;
    logic [1:0] mem_size;
    logic en_wb, use_pcp4, illegal, ecall, ebreak;
  } dec_t;
  typedef struct packed {logic [31:0] instr, pc;} ent_t;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  int errors = 0, checks = 0;
  ent_t q[$];
  bit m_acc;
  dec_t got0, got1;
  instr_decode_pipe_if #(.XLEN(32)) b0 ();
  instr_decode_pipe_if #(.XLEN(32)) b1 ();
  instr_decode_pipe #(.XLEN(32), .EN_M(1'b1), .EN_SYS(1'b1)) dut0 (.clk(clk), .rst(rst), .flush(flush), .bus(b0));
  instr_decode_pipe #(.XLEN(32), .EN_M(1'b0), .EN_SYS(1'b0)) dut1 (.clk(clk), .rst(rst), .flush(flush), .bus(b1));
  assign b1.in_valid = b0.in_valid;
  assign b1.in_instr = b0.in_instr;
  assign b1.in_pc = b0.in_pc;
  assign b1.out_ready = b0.out_ready;
  assign got0 = {b0.out_pc, b0.rs1_addr, b0.rs2_addr, b0.rd, b0.op, b0.op_choice, b0.use_imm, b0.imm,
                 b0.uncond_jmp, b0.is_branch, b0.is_mul, b0.en_mem, b0.mem_write, b0.mem_read_unsigned,
                 b0.mem_size, b0.en_wb, b0.use_pcp4, b0.illegal, b0.ecall, b0.ebreak};
  assign got1 = {b1.out_pc, b1.rs1_addr, b1.rs2_addr, b1.rd, b1.op, b1.op_choice, b1.use_imm, b1.imm,
                 b1.uncond_jmp, b1.is_branch, b1.is_mul, b1.en_mem, b1.mem_write, b1.mem_read_unsigned,
                 b1.mem_size, b1.en_wb, b1.use_pcp4, b1.illegal, b1.ecall, b1.ebreak};
  always #5 clk = ~clk;
  function automatic dec_t model(input logic [31:0] i, input logic [31:0] pc, input bit en_m, input bit en_sys);
    dec_t e;
    int f3, f7, imm_i, imm_s, imm_b, imm_j;
    bit wb;
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    imm_i = $signed(i[31:20]);
    imm_s = $signed({i[31:25], i[11:7]});
    imm_b = $signed({i[31], i[7], i[30:25], i[11:8]}) * 2;
    imm_j = $signed({i[31], i[19:12], i[20], i[30:21]}) * 2;
    e = '0;
    wb = 0;
    e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.mem_size = i[13:12];
    case (i[6:0])
      7'h37: begin e.op = 4'hB; e.use_imm = 1; e.imm = i & 32'hFFFFF000; wb = 1; end
      7'h17: begin e.op = 4'hA; e.use_imm = 1; e.imm = i & 32'hFFFFF000; wb = 1; end
      7'h6F: begin e.op = 4'hA; e.use_imm = 1; e.imm = imm_j; e.uncond_jmp = 1; e.use_pcp4 = 1; wb = 1; end
      7'h67: begin e.illegal = f3 != 0; e.use_imm = 1; e.imm = imm_i; e.uncond_jmp = 1; e.use_pcp4 = 1; wb = 1; end
      7'h63: begin e.illegal = f3 == 2 || f3 == 3; e.op = {1'b1, i[14:12]}; e.is_branch = 1; e.imm = imm_b; end
      7'h03: begin
        e.illegal = f3 == 3 || f3 >= 6; e.use_imm = 1; e.imm = imm_i;
        e.en_mem = 1; e.mem_read_unsigned = f3 >= 4; wb = 1;
      end
      7'h23: begin e.illegal = f3 > 2; e.use_imm = 1; e.imm = imm_s; e.en_mem = 1; e.mem_write = 1; end
      7'h13: begin
        e.op = {1'b0, i[14:12]}; e.use_imm = 1; e.imm = imm_i; wb = 1;
        if (f3 == 1) e.illegal = f7 != 0;
        if (f3 == 5) begin e.illegal = f7 != 0 && f7 != 32; e.op_choice = f7 == 32; end
      end
      7'h33: begin
        e.op = {1'b0, i[14:12]}; wb = 1;
        if (f7 == 32) begin e.op_choice = 1; e.illegal = f3 != 0 && f3 != 5; end
        else if (f7 == 1) begin e.is_mul = en_m; e.illegal = !en_m; end
        else e.illegal = f7 != 0;
      end
      7'h0F: ;
      7'h73: begin
        e.ecall = en_sys && i == 32'h00000073;
        e.ebreak = en_sys && i == 32'h00100073;
        e.illegal = !(e.ecall || e.ebreak);
      end
      default: e.illegal = 1;
    endcase
    if (e.illegal || e.ecall || e.ebreak) begin
      e.op = 0; e.op_choice = 0; e.use_imm = 0; e.imm = 0; e.uncond_jmp = 0; e.is_branch = 0;
      e.is_mul = 0; e.en_mem = 0; e.mem_write = 0; e.mem_read_unsigned = 0; e.use_pcp4 = 0; wb = 0;
    end
    e.en_wb = wb && e.rd != 0;
    return e;
  endfunction
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k < 11) r[6:0] = ops[k];
    if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0) r[31:25] = f7s[$urandom_range(0, 3)];
    if (k == 10 && $urandom_range(0, 1) == 0) r = $urandom_range(0, 1) ? 32'h00000073 : 32'h00100073;
    return r;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst || flush) q.delete();
    else begin
      m_acc = b0.in_valid && q.size() < 2;
      if (q.size() > 0 && b0.out_ready) void'(q.pop_front());
      if (m_acc) q.push_back({b0.in_instr, b0.in_pc});
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", b0.out_valid, q.size() > 0);
      chk("in_ready", b0.in_ready, q.size() < 2);
      chk("alt_out_valid", b1.out_valid, q.size() > 0);
      chk("alt_in_ready", b1.in_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("decode", got0, model(q[0].instr, q[0].pc, 1, 1));
        chk("decode_alt", got1, model(q[0].instr, q[0].pc, 0, 0));
      end
    end
  end
  initial begin
    dec_t m;
    b0.in_valid = 0; b0.in_instr = 0; b0.in_pc = 0; b0.out_ready = 0;
    #1 rst = 1;
    step(); step();
    chk("reset_outputs", got0, 0);
    chk("reset_hs", {b0.out_valid, b0.in_ready}, 2'b01);
    rst = 0;
    m = model(32'hFFDFF06F, 0, 1, 1);
    chk("pin_jal", {m.imm, m.op, m.uncond_jmp, m.use_pcp4, m.en_wb}, {32'hFFFFFFFC, 4'hA, 1'b1, 1'b1, 1'b0});
    m = model(32'h12345037, 0, 1, 1);
    chk("pin_lui_x0", {m.imm, m.op, m.en_wb}, {32'h12345000, 4'hB, 1'b0});
    m = model(32'h0000A003, 0, 1, 1);
    chk("pin_lw_x0", {m.en_mem, m.en_wb, m.mem_size, m.illegal}, {1'b1, 1'b0, 2'b10, 1'b0});
    m = model(32'h0020A223, 0, 1, 1);
    chk("pin_sw", {m.imm, m.mem_write, m.en_mem}, {32'd4, 1'b1, 1'b1});
    m = model(32'h0000000F, 0, 1, 1);
    chk("pin_fence", {m.illegal, m.en_mem, m.en_wb, m.op}, 0);
    b0.out_ready = 1;
    b0.in_valid = 1; b0.in_instr = 32'h00500093; b0.in_pc = 32'h100; step(); b0.in_valid = 0;
    chk("addi", {b0.out_valid, b0.op, b0.use_imm, b0.imm, b0.rd, b0.en_wb, b0.op_choice},
        {1'b1, 4'h0, 1'b1, 32'd5, 5'd1, 1'b1, 1'b0});
    b0.in_valid = 1; b0.in_instr = 32'h402081B3; b0.in_pc = 32'h104; step(); b0.in_valid = 0;
    chk("sub", {b0.op, b0.op_choice, b0.use_imm, b0.imm}, {4'h0, 1'b1, 1'b0, 32'd0});
    b0.in_valid = 1; b0.in_instr = 32'hFE000CE3; b0.in_pc = 32'h108; step(); b0.in_valid = 0;
    chk("beq", {b0.is_branch, b0.op, b0.imm, b0.en_wb}, {1'b1, 4'h8, 32'hFFFFFFF8, 1'b0});
    b0.in_valid = 1; b0.in_instr = 32'h027302B3; b0.in_pc = 32'h10C; step(); b0.in_valid = 0;
    chk("mul_m", {b0.is_mul, b0.op, b0.rd, b0.illegal}, {1'b1, 4'h0, 5'd5, 1'b0});
    chk("mul_no_m", {b1.illegal, b1.en_wb, b1.is_mul}, 3'b100);
    b0.in_valid = 1; b0.in_instr = 32'h00000073; b0.in_pc = 32'h110; step(); b0.in_valid = 0;
    chk("ecall", {b0.ecall, b0.en_mem, b0.en_wb, b0.uncond_jmp, b0.is_branch, b0.illegal}, 6'b100000);
    chk("ecall_no_sys", {b1.ecall, b1.illegal}, 2'b01);
    b0.in_valid = 1; b0.in_instr = 32'h0000007F; b0.in_pc = 32'h114; step(); b0.in_valid = 0;
    chk("bad_opcode", {b0.illegal, b0.en_wb}, 2'b10);
    step();
    b0.out_ready = 0;
    b0.in_valid = 1; b0.in_instr = 32'h00100093; b0.in_pc = 32'h200; step();
    b0.in_instr = 32'h00200113; b0.in_pc = 32'h204; step();
    b0.in_instr = 32'h00300193; b0.in_pc = 32'h208;
    chk("bp_in_ready", b0.in_ready, 0);
    step();
    chk("bp_hold", {b0.out_valid, b0.out_pc, b0.imm, b0.in_ready}, {1'b1, 32'h200, 32'd1, 1'b0});
    b0.in_valid = 0; b0.out_ready = 1; step();
    chk("drain1", {b0.out_valid, b0.out_pc, b0.imm}, {1'b1, 32'h204, 32'd2});
    step();
    chk("drain2", b0.out_valid, 0);
    b0.out_ready = 0;
    b0.in_valid = 1; b0.in_instr = 32'h00100093; b0.in_pc = 32'h300; step();
    b0.in_pc = 32'h304; step();
    flush = 1; b0.in_pc = 32'h308; step(); flush = 0; b0.in_valid = 0;
    chk("flush_skid", {b0.out_valid, b0.in_ready}, 2'b01);
    b0.out_ready = 1; step();
    chk("flush_skid_empty", b0.out_valid, 0);
    b0.out_ready = 0;
    b0.in_valid = 1; b0.in_pc = 32'h310; step();
    flush = 1; b0.in_pc = 32'h314; step(); flush = 0; b0.in_valid = 0;
    chk("flush_full_accept", {b0.out_valid, b0.in_ready}, 2'b01);
    step();
    chk("flush_full_empty", b0.out_valid, 0);
    b0.in_valid = 1; b0.in_instr = 32'h00500093; b0.in_pc = 32'h400; step(); b0.in_valid = 0;
    #1 rst = 1;
    #1 chk("async_rst", {b0.out_valid, b0.in_ready, got0}, {1'b0, 1'b1, 98'd0});
    step(); rst = 0;
    for (int c = 0; c < 4000; c++) begin
      b0.in_valid = $urandom_range(0, 3) != 0;
      b0.out_ready = (c / 400) % 2 == 1 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 31) == 0;
      b0.in_instr = rand_instr();
      b0.in_pc = $urandom;
      step();
    end
    flush = 0; b0.in_valid = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
